// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state/op encodings and default operand width for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: combinational WIDTH+1-bit adder/subtractor with carry-out
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y,
  output logic           cout
);
  logic [WIDTH:0] bx;
  assign bx = b ^ {(WIDTH+1){sub}};
  assign {cout, y} = {1'b0, a} + {1'b0, bx} + {{(WIDTH+1){1'b0}}, sub};
endmodule

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module mul_div_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_lo_q, w_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0] w_hi_q, w_hi_d;
  logic [WIDTH:0] as_a, as_b, as_y, mul_s, nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic as_co;
  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(as_a), .b(as_b), .sub(op_q), .y(as_y), .cout(as_co)
  );
  // divide: carry-out of rem-B is set exactly when the trial remainder is non-negative
  always_comb begin
    as_a   = op_q ? {w_hi_q[WIDTH-1:0], w_lo_q[WIDTH-1]} : w_hi_q;
    as_b   = {1'b0, op_q ? b_q : a_q};
    mul_s  = w_lo_q[0] ? as_y : as_a;
    nxt_hi = op_q ? (as_co ? as_y : as_a) : {1'b0, mul_s[WIDTH:1]};
    nxt_lo = op_q ? {w_lo_q[WIDTH-2:0], as_co} : {mul_s[0], w_lo_q[WIDTH-1:1]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    w_hi_d  = w_hi_q;
    w_lo_d  = w_lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        busy_d  = 1'b1;
        op_d    = op;
        a_d     = A;
        b_d     = B;
        cnt_d   = '0;
        dz_d    = 1'b0;
        w_hi_d  = '0;
        w_lo_d  = (op == OP_DIV) ? A : B;
      end
      CALC: begin
        cnt_d  = cnt_q + CW'(1);
        w_hi_d = nxt_hi;
        w_lo_d = nxt_lo;
        if (op_q == OP_DIV && b_q == '0) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = a_q;
          lo_d    = '1;
          dz_d    = 1'b1;
        end else if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = nxt_hi[WIDTH-1:0];
          lo_d    = nxt_lo;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      w_hi_q  <= '0;
      w_lo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_hi_q  <= w_hi_d;
      w_lo_q  <= w_lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = dz_q;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb_mul_div_ctrl: directed multiply/divide vectors with hand-computed results, latency and reset checks
module tb_mul_div_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, op = 1'b0;
  logic [31:0] A = '0, B = '0, hi, lo;
  logic busy, done, divZero;
  int n_cmp = 0, n_err = 0;
  int n, pulses;
  mul_div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b, input int inj, output int cyc);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == inj) begin start = 1'b1; op = ~o; end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
  endtask
  task automatic count_done(input int cycles, output int p);
    p = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done === 1'b1) p++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", divZero, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 32'd7, 32'd6, -1, n);
    chk("mul7x6_lat", n, 32);
    chk("mul7x6_hi", hi, 0);
    chk("mul7x6_lo", lo, 42);
    chk("mul7x6_dz", divZero, 0);
    chk("mul7x6_busy", busy, 0);
    @(posedge clk); #1;
    chk("mul7x6_pulse", done, 0);
    chk("mul7x6_hold", lo, 42);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, n);
    chk("mulmax_lat", n, 32);
    chk("mulmax_hi", hi, 32'hFFFF_FFFE);
    chk("mulmax_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    run(1'b1, 32'd100, 32'd7, 5, n);
    chk("div100_lat", n, 32);
    chk("div100_lo", lo, 14);
    chk("div100_hi", hi, 2);
    count_done(40, pulses);
    chk("div100_once", pulses, 0);
    run(1'b1, 32'd5, 32'd0, -1, n);
    chk("dz_lat", n, 1);
    chk("dz_flag", divZero, 1);
    chk("dz_hi", hi, 5);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_held", divZero, 1);
    op = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_clear", divZero, 0);
    chk("abort_busy_pre", busy, 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1; rst = 1'b1;
    count_done(40, pulses);
    chk("abort_nodone", pulses, 0);
    chk("abort_idle", busy, 0);
    run(1'b1, 32'd9, 32'd3, -1, n);
    chk("div9_lat", n, 32);
    chk("div9_lo", lo, 3);
    chk("div9_hi", hi, 0);
    @(posedge clk); #1;
    run(1'b0, 32'd7, 32'd6, -1, n);
    chk("b2b_first_lo", lo, 42);
    op = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ignored", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (n == 16) begin
        chk("b2b_hold_hi", hi, 0);
        chk("b2b_hold_lo", lo, 42);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_lat", n, 32);
    chk("b2b_lo", lo, 14);
    chk("b2b_hi", hi, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
